spi_mnrch: RTL and testbench
============================

# spi_mnrch

SPI monarch that runs one 16-bit full-duplex mode-3 transaction per request. It drives SS_n/SCLK/MOSI and samples MISO. It sits directly upstream of the iNEMO inertial sensor serf and is the only path by which the inertial interface issues register writes (setup) and reads (who-am-I, rate/accel bytes). SCLK is clk/16, MSB first, and the received word is returned on rd_data with a sticky done.

## Interface
- Parameters: none. Frame length (16) and divide ratio (16) are fixed.
- clk  in  1  system clock (50 MHz), all flops on rising edge
- rst_n  in  1  asynchronous active-low reset
- wrt  in  1  one-cycle request to start a transaction; ignored unless IDLE
- wt_data  in  16  word to transmit, MSB first, captured on the edge that accepts wrt
- done  out  1  high when the transaction is complete; stays high until the next accepted wrt
- rd_data  out  16  word received on MISO; valid while done=1
- SS_n  out  1  active-low serf select, registered (glitch-free)
- SCLK  out  1  serial clock = clk/16, idles high
- MOSI  out  1  serial data out = shift register [15]
- MISO  in  1  serial data in from serf

## Operation
- Datapath:
  - 4-bit SCLK divider `div`; SCLK = div[3].
  - 16-bit shift register `shft`; MOSI = shft[15]; rd_data = shft.
  - MISO sample flop `smpl`.
  - 4-bit bit counter `bit_cnt`.
- Divider constants:
  - FRONT_LD = 4'b1011, which gives SCLK high and a short front porch.
  - SMPL_PT = 4'b0111, the cycle before an SCLK rise.
  - SHFT_PT = 4'b1111, the cycle before an SCLK fall.
- States IDLE, FRONT, SHIFT, BACK.
- IDLE:
  - div is held at FRONT_LD.
  - On wrt: shft ← wt_data, bit_cnt ← 0, SS_n ← 0, done ← 0; go to FRONT.
- FRONT:
  - div increments every clk.
  - At div == SHFT_PT, go to SHIFT with no shift; div wraps to 0, which produces the first SCLK fall.
  - The serf sees the MSB already on MOSI.
- SHIFT:
  - div free-runs.
  - At SMPL_PT: smpl ← MISO.
  - At SHFT_PT: shft ← {shft[14:0], smpl} and bit_cnt increments.
  - When this is the 15th shift (bit_cnt == 14 before the increment), go to BACK.
- BACK:
  - div free-runs.
  - At SMPL_PT: sample the 16th bit.
  - At SHFT_PT:
    - perform the 16th shift;
    - reload div ← FRONT_LD, so SCLK does not fall;
    - SS_n ← 1, done ← 1;
    - go to IDLE.
- Reset values: SS_n=1, SCLK=1 (div=FRONT_LD), done=0, rd_data=16'h0000, MOSI=0, state IDLE.

## Timing
- Edge 0 is the edge that accepts wrt; SS_n falls at edge 0.
- FRONT occupies edges 1–5, with the first SCLK fall at edge 5.
- SHIFT occupies 15 SCLK periods, 240 clks.
- BACK occupies 16 clks.
- done and SS_n rise at edge 261. rd_data is final at the same edge.
- SCLK has 16 rising edges per frame, each 8 clks after the preceding fall. MISO is sampled 1 clk before each rise.
- MOSI changes only on the clk after an SCLK fall, so it is stable for 8 clks around every rise.
- wrt during FRONT/SHIFT/BACK: ignored; no restart, wt_data is not re-captured.
- wrt in the first IDLE cycle after done: accepted; done clears on that edge and the new frame begins, giving back-to-back frames with 1 idle clk.
- rst_n asserted mid-frame: all outputs go to reset values immediately. SS_n rises, which aborts the frame at the serf. No partial data is reported.
- The divider wraps modulo 16. bit_cnt never exceeds 15 before BACK completes.

## Structure
- Package `spi_mnrch_pkg` holds:
  - the state enum `spi_state_t`;
  - FRONT_LD, SMPL_PT, SHFT_PT;
  - NUM_BITS = 16.
- Single flat module; no sub-module.
- SS_n and done use dedicated set/reset flops.
- SCLK comes straight from the div[3] flop (no combinational decode).

## Test plan
- MISO tied to MOSI, wt_data=16'hA5C3 → done rises at edge 261, rd_data=16'hA5C3, exactly 16 SCLK rises, SS_n low throughout.
- With the serf model, after its power-on delay, wt_data=16'h8F00 (read WHO_AM_I) → rd_data=16'h006A.
- With the serf: write 16'h0D02 → rd_data=16'h00A5. Then read 16'h8D00 → rd_data[7:0]=8'h02.
- wrt pulsed repeatedly mid-frame (edges 50, 150, 255) → single frame, rd_data unchanged by the extra pulses, done at edge 261.
- rst_n pulsed low at edge 100 → SS_n=1, SCLK=1, done=0 within the same cycle. A following wrt completes normally.
- Back-to-back: wrt in the first IDLE cycle after done (16'h1234 then 16'hFEDC, loopback) → both rd_data values correct, done low for exactly the 261-clk second frame.

Source files
------------

// File: rtl/spi_mnrch_pkg.sv
// -----------------------------------------------------------------------------
// spi_mnrch_pkg
//   Shared definitions for the SPI monarch: the frame state encoding and
//   the divider compare points that place SCLK edges, MISO sampling and
//   MOSI shifting inside each 16-clk SCLK period.
// -----------------------------------------------------------------------------
package spi_mnrch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } spi_state_t;

    // Divider load value while idle: div[3]=1 keeps SCLK high, and the
    // count from here to SHFT_PT forms the short front porch.
    localparam logic [3:0] FRONT_LD = 4'b1011;
    // Last clk before SCLK rises (div 7 -> 8): MISO is captured here.
    localparam logic [3:0] SMPL_PT  = 4'b0111;
    // Last clk before SCLK falls (div 15 -> 0): the shift register moves here.
    localparam logic [3:0] SHFT_PT  = 4'b1111;

    localparam int NUM_BITS = 16;

    // bit_cnt value seen at the 15th shift; the 16th shift happens in BACK.
    localparam logic [3:0] LAST_SHIFT_CNT = 4'(NUM_BITS - 2);

endpackage

// File: rtl/spi_mnrch.sv
// -----------------------------------------------------------------------------
// spi_mnrch
//   SPI monarch running one 16-bit full-duplex mode-3 transaction per
//   request. SCLK = clk/16 and idles high, data is MSB first. The word
//   received on MISO is returned on rd_data together with a sticky done.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wrt      in   one-cycle start request, honoured only while idle
//   wt_data  in   16-bit word to transmit, captured when wrt is accepted
//   done     out  frame complete; held until the next accepted wrt
//   rd_data  out  16-bit word received from the serf (valid while done)
//   SS_n     out  active-low serf select, straight from a flop
//   SCLK     out  serial clock, straight from divider bit 3
//   MOSI     out  serial data out, MSB of the shift register
//   MISO     in   serial data in from the serf
// -----------------------------------------------------------------------------
module spi_mnrch
    import spi_mnrch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    spi_state_t  r_state;
    spi_state_t  w_nxt_state;

    logic [3:0]  r_div;
    logic [15:0] r_shft;
    logic        r_smpl;
    logic [3:0]  r_bit_cnt;
    logic        r_ss_n;
    logic        r_done;

    logic        w_init;     // accept wrt: load shifter, open the frame
    logic        w_div_ld;   // park the divider at FRONT_LD
    logic        w_smpl;     // capture MISO this clk
    logic        w_shft;     // shift the frame register this clk
    logic        w_cnt_inc;  // count a shift taken in SHIFT
    logic        w_final;    // 16th shift: close the frame

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_nxt_state = r_state;
        w_init      = 1'b0;
        w_div_ld    = 1'b0;
        w_smpl      = 1'b0;
        w_shft      = 1'b0;
        w_cnt_inc   = 1'b0;
        w_final     = 1'b0;

        case (r_state)
            IDLE: begin
                w_div_ld = 1'b1;
                if (wrt) begin
                    w_init      = 1'b1;
                    w_nxt_state = FRONT;
                end
            end

            // Front porch: no shift here. The divider wrapping 15 -> 0 on
            // the exit edge produces the first SCLK fall, while the MSB has
            // been on MOSI since the frame was accepted.
            FRONT: begin
                if (r_div == SHFT_PT) begin
                    w_nxt_state = SHIFT;
                end
            end

            SHIFT: begin
                if (r_div == SMPL_PT) begin
                    w_smpl = 1'b1;
                end
                if (r_div == SHFT_PT) begin
                    w_shft    = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_bit_cnt == LAST_SHIFT_CNT) begin
                        w_nxt_state = BACK;
                    end
                end
            end

            // Back porch: take the 16th bit, then reload the divider instead
            // of letting it wrap so SCLK stays high as SS_n rises.
            BACK: begin
                if (r_div == SMPL_PT) begin
                    w_smpl = 1'b1;
                end
                if (r_div == SHFT_PT) begin
                    w_shft      = 1'b1;
                    w_final     = 1'b1;
                    w_div_ld    = 1'b1;
                    w_nxt_state = IDLE;
                end
            end

            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // SCLK divider: free-running except while parked or at end of frame
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= FRONT_LD;
        end else if (w_div_ld) begin
            r_div <= FRONT_LD;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Shift register, MISO sample flop and bit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shft    <= 16'h0000;
            r_smpl    <= 1'b0;
            r_bit_cnt <= 4'd0;
        end else begin
            if (w_init) begin
                r_shft <= wt_data;
            end else if (w_shft) begin
                r_shft <= {r_shft[14:0], r_smpl};
            end

            if (w_smpl) begin
                r_smpl <= MISO;
            end

            if (w_init) begin
                r_bit_cnt <= 4'd0;
            end else if (w_cnt_inc) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Set/reset flops for SS_n and done
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_n <= 1'b1;
            r_done <= 1'b0;
        end else begin
            if (w_init) begin
                r_ss_n <= 1'b0;
                r_done <= 1'b0;
            end else if (w_final) begin
                r_ss_n <= 1'b1;
                r_done <= 1'b1;
            end
        end
    end

    assign SS_n    = r_ss_n;
    assign SCLK    = r_div[3];
    assign MOSI    = r_shft[15];
    assign rd_data = r_shft;
    assign done    = r_done;

endmodule

// File: tb/tb_spi_mnrch.sv
// -----------------------------------------------------------------------------
// tb_spi_mnrch
//   Scoreboarded bench for spi_mnrch. MISO is either looped back from MOSI
//   or driven by a small behavioural inertial-sensor serf (power-on delay,
//   WHO_AM_I = 0x6A, writes answer 0xA5, reads return the register).
// -----------------------------------------------------------------------------
module tb_spi_mnrch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] wt_data = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    logic        loopback = 1'b1;
    logic        serf_miso = 1'b0;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int last_issue = 0;

    localparam int FRAME_CLKS = 261;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
        int          issue;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] ref_regs  [0:127];
    logic [7:0] serf_regs [0:127];

    assign MISO = loopback ? MOSI : serf_miso;

    spi_mnrch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: still running after %0d cycles, required to finish earlier", 60000);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model of the serf register file.
    task automatic ref_xfer(input logic [15:0] w, output logic [15:0] r);
        if (w[15]) begin
            r = {8'h00, ref_regs[w[14:8]]};
        end else begin
            ref_regs[w[14:8]] = w[7:0];
            r = 16'h00A5;
        end
    endtask

    // ------------------------------------------------------------------------
    // Serf model: mode 3, drives MISO after each SCLK fall, reads MOSI after
    // each SCLK rise, decides the response byte once the command byte is in.
    // ------------------------------------------------------------------------
    logic [15:0] s_out = 16'h0000;
    logic [15:0] s_rx = 16'h0000;
    int          s_falls = 0;
    int          s_rises = 0;
    logic        s_ss_p = 1'b1;
    logic        s_sclk_p = 1'b1;

    always @(negedge clk) begin
        if (s_ss_p && !SS_n) begin
            s_out     = 16'h0000;
            s_rx      = 16'h0000;
            s_falls   = 0;
            s_rises   = 0;
            serf_miso = 1'b0;
        end else if (!SS_n) begin
            if (s_sclk_p && !SCLK && s_falls < 16) begin
                serf_miso = s_out[4'(15 - s_falls)];
                s_falls++;
            end
            if (!s_sclk_p && SCLK) begin
                s_rx = {s_rx[14:0], MOSI};
                s_rises++;
                if (s_rises == 8 && cyc >= 50) begin
                    s_out[7:0] = s_rx[7] ? serf_regs[s_rx[6:0]] : 8'hA5;
                end
            end
        end
        if (!s_ss_p && SS_n && s_rises == 16 && cyc >= 50 && !loopback && !s_rx[15]) begin
            serf_regs[s_rx[14:8]] = s_rx[7:0];
        end
        s_ss_p   = SS_n;
        s_sclk_p = SCLK;
    end

    // ------------------------------------------------------------------------
    // Monitor: watches the bus each frame and scores every done rise.
    // ------------------------------------------------------------------------
    logic        m_ss_p = 1'b1;
    logic        m_sclk_p = 1'b1;
    logic        m_done_p = 1'b0;
    int          m_rises = 0;
    logic [15:0] m_mosi_w = 16'h0000;

    always @(negedge clk) begin
        if (m_ss_p && !SS_n) begin
            m_rises  = 0;
            m_mosi_w = 16'h0000;
        end
        if (!SS_n && SCLK && !m_sclk_p) begin
            m_rises++;
            m_mosi_w = {m_mosi_w[14:0], MOSI};
        end
        if (done && !m_done_p) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: done rose at cycle %0d, expected no outstanding frame", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rd_data",    rd_data,           e.rx);
                check("latency",    cyc - e.issue,     FRAME_CLKS);
                check("sclk_rises", m_rises,           16);
                check("mosi_word",  m_mosi_w,          e.tx);
                check("ss_n_end",   SS_n,              1'b1);
                check("sclk_end",   SCLK,              1'b1);
            end
        end
        m_ss_p   = SS_n;
        m_sclk_p = SCLK;
        m_done_p = done;
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic start(input logic [15:0] w, input logic [15:0] exp_rx, input bit immediate);
        exp_t e;
        if (!immediate) @(negedge clk);
        wrt     = 1'b1;
        wt_data = w;
        e.tx    = w;
        e.rx    = exp_rx;
        e.issue = cyc + 1;
        last_issue = e.issue;
        sb_q.push_back(e);
        @(negedge clk);
        wrt     = 1'b0;
        wt_data = 16'($urandom);
        check("done_clear", done, 1'b0);
        check("ss_n_low",   SS_n, 1'b0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, k);
            sb_q.delete();
        end
    endtask

    task automatic pulse_at(input int e);
        while (cyc < last_issue + e - 1) @(negedge clk);
        wrt     = 1'b1;
        wt_data = 16'($urandom);
        @(negedge clk);
        wrt     = 1'b0;
    endtask

    task automatic reset_at(input logic [15:0] w, input int e);
        start(w, w, 1'b0);
        while (cyc < last_issue + e - 1) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ss_n",    SS_n,    1'b1);
        check("rst_sclk",    SCLK,    1'b1);
        check("rst_done",    done,    1'b0);
        check("rst_rd_data", rd_data, 16'h0000);
        check("rst_mosi",    MOSI,    1'b0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [15:0] w;
    logic [15:0] r;
    logic [6:0]  a;
    logic [7:0]  d;
    logic        rw;
    int          gap;

    initial begin
        for (int i = 0; i < 128; i++) begin
            ref_regs[i]  = 8'h00;
            serf_regs[i] = 8'h00;
        end
        ref_regs[7'h0F]  = 8'h6A;
        serf_regs[7'h0F] = 8'h6A;

        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("init_ss_n",    SS_n,    1'b1);
        check("init_sclk",    SCLK,    1'b1);
        check("init_done",    done,    1'b0);
        check("init_rd_data", rd_data, 16'h0000);
        check("init_mosi",    MOSI,    1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback: received word equals transmitted word.
        start(16'hA5C3, 16'hA5C3, 1'b0);
        wait_done();

        // Extra wrt pulses inside a frame are ignored.
        start(16'h3C5A, 16'h3C5A, 1'b0);
        pulse_at(50);
        pulse_at(150);
        pulse_at(255);
        wait_done();

        // Mid-frame reset, then a normal frame.
        reset_at(16'h5A5A, 100);
        reset_at(16'h0FF0, 106);
        start(16'hC0DE, 16'hC0DE, 1'b0);
        wait_done();

        // Back-to-back: second wrt in the first idle cycle after done.
        start(16'h1234, 16'h1234, 1'b0);
        wait_done();
        start(16'hFEDC, 16'hFEDC, 1'b1);
        wait_done();

        // Random loopback frames with random gaps and stray wrt pulses.
        for (int i = 0; i < 8; i++) begin
            w   = 16'($urandom);
            gap = $urandom_range(0, 3);
            if (gap == 0) begin
                start(w, w, 1'b1);
            end else begin
                repeat (gap - 1) @(negedge clk);
                start(w, w, 1'b0);
            end
            if (i % 3 == 1) pulse_at($urandom_range(1, 260));
            wait_done();
        end

        // Serf traffic.
        @(negedge clk);
        loopback = 1'b0;
        ref_xfer(16'h8F00, r);
        start(16'h8F00, 16'h006A, 1'b0);
        wait_done();
        ref_xfer(16'h0D02, r);
        start(16'h0D02, 16'h00A5, 1'b0);
        wait_done();
        ref_xfer(16'h8D00, r);
        start(16'h8D00, 16'h0002, 1'b0);
        wait_done();

        for (int i = 0; i < 10; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 15));
            d  = 8'($urandom);
            w  = {rw, a, d};
            ref_xfer(w, r);
            start(w, r, 1'b0);
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
